// File: rtl/flash_adc_conv_ctrl.sv
// rtl/flash_adc_conv_ctrl.sv - flash ADC conversion sequencer with bubble correction and 2^k averaging
module flash_adc_conv_ctrl #(
    parameter int N_CMP        = 256,
    parameter int OUT_W        = 8,
    parameter int SETTLE_CYC   = 2,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       avg_log2,
    input  logic [N_CMP-1:0] cmp_in,
    output logic             cmp_strobe,
    output logic             busy,
    output logic [OUT_W-1:0] code_out,
    output logic             code_valid,
    input  logic             code_ready,
    output logic             bubble_err,
    output logic             overrange
);

    localparam int ACC_W = OUT_W + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_SETTLE,
        S_CAPTURE,
        S_ENCODE,
        S_DONE
    } state_t;

    state_t             state;
    logic [2:0]         k_reg;
    logic [CNT_W-1:0]   sample_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [N_CMP-1:0]   cap_reg;
    logic [ACC_W-1:0]   acc;
    logic               bub_acc;
    logic               ovr_acc;

    logic [N_CMP+1:0]   ext;
    logic [N_CMP-1:0]   corr;
    logic [OUT_W-1:0]   code;
    logic [ACC_W-1:0]   acc_next;
    logic [OUT_W-1:0]   code_shift;
    logic [CNT_W-1:0]   last_idx;
    logic [2:0]         k_clamp;
    logic               begin_conv;
    logic               bub_next;
    logic               ovr_next;

    // Pad the captured code with a virtual 1 below bit 0 and a virtual 0 above the top bit
    always_comb begin
        ext = {1'b0, cap_reg, 1'b1};
        corr = '0;
        for (int i = 0; i < N_CMP; i++) begin
            corr[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    always_comb begin
        code = '0;
        for (int i = 0; i < N_CMP; i++) begin
            if (corr[i]) begin
                code = OUT_W'(i);
            end
        end
    end

    always_comb begin
        acc_next   = acc + ACC_W'(code);
        code_shift = OUT_W'(acc_next >> k_reg);
        last_idx   = CNT_W'((32'd1 << k_reg) - 32'd1);
        k_clamp    = (avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : avg_log2;
        bub_next   = bub_acc | (corr != cap_reg);
        ovr_next   = ovr_acc | corr[N_CMP-1];
        begin_conv = start && ((state == S_IDLE) || (state == S_DONE && code_ready));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            k_reg      <= '0;
            sample_cnt <= '0;
            settle_cnt <= '0;
            cap_reg    <= '0;
            acc        <= '0;
            bub_acc    <= 1'b0;
            ovr_acc    <= 1'b0;
            cmp_strobe <= 1'b0;
            busy       <= 1'b0;
            code_out   <= '0;
            code_valid <= 1'b0;
            bubble_err <= 1'b0;
            overrange  <= 1'b0;
        end else if (abort && state != S_IDLE) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            acc        <= '0;
            bub_acc    <= 1'b0;
            ovr_acc    <= 1'b0;
            cmp_strobe <= 1'b0;
            busy       <= 1'b0;
            code_out   <= '0;
            code_valid <= 1'b0;
            bubble_err <= 1'b0;
            overrange  <= 1'b0;
        end else if (begin_conv) begin
            // Fresh start from IDLE, or back-to-back restart on the DONE handshake
            state      <= S_STROBE;
            k_reg      <= k_clamp;
            sample_cnt <= '0;
            acc        <= '0;
            bub_acc    <= 1'b0;
            ovr_acc    <= 1'b0;
            cmp_strobe <= 1'b1;
            busy       <= 1'b1;
            code_out   <= '0;
            code_valid <= 1'b0;
            bubble_err <= 1'b0;
            overrange  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                end
                S_STROBE: begin
                    cmp_strobe <= 1'b0;
                    settle_cnt <= SET_W'(SETTLE_CYC - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    cap_reg <= cmp_in;
                    state   <= S_ENCODE;
                end
                S_ENCODE: begin
                    acc     <= acc_next;
                    bub_acc <= bub_next;
                    ovr_acc <= ovr_next;
                    if (sample_cnt == last_idx) begin
                        state      <= S_DONE;
                        code_valid <= 1'b1;
                        code_out   <= code_shift;
                        bubble_err <= bub_next;
                        overrange  <= ovr_next;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                        cmp_strobe <= 1'b1;
                        state      <= S_STROBE;
                    end
                end
                S_DONE: begin
                    if (code_ready) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        acc        <= '0;
                        bub_acc    <= 1'b0;
                        ovr_acc    <= 1'b0;
                        code_valid <= 1'b0;
                        code_out   <= '0;
                        bubble_err <= 1'b0;
                        overrange  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_adc_conv_ctrl.sv
// tb/tb_flash_adc_conv_ctrl.sv - directed-vector bench for flash_adc_conv_ctrl
module tb_flash_adc_conv_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [2:0]   avg_log2;
    logic [255:0] cmp_in;
    logic         cmp_strobe;
    logic         busy;
    logic [7:0]   code_out;
    logic         code_valid;
    logic         code_ready;
    logic         bubble_err;
    logic         overrange;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int seq[16];
    int seq_n = 0;

    flash_adc_conv_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .avg_log2   (avg_log2),
        .cmp_in     (cmp_in),
        .cmp_strobe (cmp_strobe),
        .busy       (busy),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .bubble_err (bubble_err),
        .overrange  (overrange)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] therm(input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n && i < 256; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Start a conversion at a negedge, run until code_valid or the budget expires.
    // On each strobe, cmp_in is reloaded from seq[] when a sequence is loaded.
    task automatic run_conv(input logic [2:0] k, input int budget,
                            output int str_lat, output int val_lat, output int nstr);
        int t0;
        @(negedge clk);
        avg_log2 = k;
        start = 1'b1;
        t0 = cyc;
        nstr = 0;
        str_lat = -1;
        val_lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (cmp_strobe) begin
                if (str_lat < 0) str_lat = cyc - t0;
                if (nstr < seq_n) cmp_in = therm(seq[nstr] + 1);
                nstr++;
            end
            if (code_valid) begin
                val_lat = cyc - t0;
                break;
            end
        end
        check_val("valid_reached", code_valid, 1);
    endtask

    task automatic accept(input string tag);
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        check_val({tag, "_valid_drop"}, code_valid, 0);
        check_val({tag, "_code_clr"}, code_out, 0);
    endtask

    int sl, vl, ns;
    logic seen;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        avg_log2 = 3'd0;
        cmp_in = '0;
        code_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_strobe", cmp_strobe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_valid", code_valid, 0);
        check_val("rst_code", code_out, 0);
        check_val("rst_bubble", bubble_err, 0);
        check_val("rst_over", overrange, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: clean thermometer, k=0
        cmp_in = therm(100);
        run_conv(3'd0, 40, sl, vl, ns);
        check_val("t1_strobe_lat", sl, 1);
        check_val("t1_valid_lat", vl, 6);
        check_val("t1_code", code_out, 99);
        check_val("t1_bubble", bubble_err, 0);
        check_val("t1_over", overrange, 0);
        check_val("t1_busy", busy, 1);
        accept("t1");
        check_val("t1_busy_idle", busy, 0);

        // 2: bubble at bit 50 and stray bit 102
        cmp_in = therm(100);
        cmp_in[50] = 1'b0;
        cmp_in[102] = 1'b1;
        run_conv(3'd0, 40, sl, vl, ns);
        check_val("t2_code", code_out, 99);
        check_val("t2_bubble", bubble_err, 1);
        check_val("t2_over", overrange, 0);
        accept("t2");

        // 3: k=2 averaging of codes 10..13
        seq[0] = 10; seq[1] = 11; seq[2] = 12; seq[3] = 13; seq_n = 4;
        cmp_in = therm(11);
        run_conv(3'd2, 60, sl, vl, ns);
        seq_n = 0;
        check_val("t3_valid_lat", vl, 21);
        check_val("t3_code", code_out, 11);
        check_val("t3_strobes", ns, 4);
        check_val("t3_bubble", bubble_err, 0);
        accept("t3");

        // 4: backpressure with start held, then restart on handshake
        cmp_in = therm(40);
        run_conv(3'd0, 40, sl, vl, ns);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("t4_hold_valid", code_valid, 1);
            check_val("t4_hold_code", code_out, 39);
            check_val("t4_no_strobe", cmp_strobe, 0);
        end
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        start = 1'b0;
        check_val("t4_restart_strobe", cmp_strobe, 1);
        check_val("t4_restart_valid", code_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = code_valid;
        end
        check_val("t4_second_valid", seen, 1);
        check_val("t4_second_code", code_out, 39);
        accept("t4");

        // 5a: abort during SETTLE
        @(negedge clk);
        avg_log2 = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("t5_abort_busy", busy, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | code_valid;
        end
        check_val("t5_abort_novalid", seen, 0);

        // 5b: reset during the first ENCODE with k=3
        cmp_in = therm(200);
        @(negedge clk);
        avg_log2 = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("t5_rst_busy", busy, 0);
        check_val("t5_rst_strobe", cmp_strobe, 0);
        check_val("t5_rst_valid", code_valid, 0);
        check_val("t5_rst_code", code_out, 0);

        // 6: full-scale, zero-scale, clamped k
        cmp_in = '1;
        run_conv(3'd0, 40, sl, vl, ns);
        check_val("t6_full_code", code_out, 255);
        check_val("t6_full_over", overrange, 1);
        check_val("t6_full_bubble", bubble_err, 0);
        accept("t6f");
        cmp_in = '0;
        run_conv(3'd0, 40, sl, vl, ns);
        check_val("t6_zero_code", code_out, 0);
        check_val("t6_zero_over", overrange, 0);
        check_val("t6_zero_bubble", bubble_err, 0);
        accept("t6z");
        cmp_in = therm(5);
        run_conv(3'd7, 200, sl, vl, ns);
        check_val("t6_k7_strobes", ns, 16);
        check_val("t6_k7_valid_lat", vl, 81);
        check_val("t6_k7_code", code_out, 4);
        accept("t6k");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
